// File: rtl/tick_sched.sv
// tick_sched: shared prescaler dividing one counter into NCH single-cycle enable ticks.
// Define TICK_SCHED_ACK_EN to turn ticks into acknowledged level requests with overrun flags.
module tick_sched #(
    parameter int NCH  = 4,
    parameter int CHW  = 2,
    parameter int CW   = 24,
    parameter int SELW = 5
) (
    input  logic            mclk,
    input  logic            clr,
    input  logic            halt,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [SELW-1:0] cfg_sel,
    input  logic [1:0]      cfg_mode,
`ifdef TICK_SCHED_ACK_EN
    input  logic [NCH-1:0]  tick_ack,
    output logic [NCH-1:0]  ovr,
`endif
    output logic            cfg_ack,
    output logic            cfg_err,
    output logic [CW-1:0]   cnt,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  armed
);
    logic [CW-1:0]   nxt;
    logic [NCH-1:0]  one, hit, wr;
    logic [SELW-1:0] sel [NCH];
    logic            ok;

    // A tick is a 0->1 edge of the selected bit, judged on the old configuration.
    always_comb begin
        nxt = cnt + 1'b1;
        ok = cfg_we && 32'(cfg_ch) < NCH && !((cfg_mode[0] ^ cfg_mode[1]) && 32'(cfg_sel) >= CW);
        for (int c = 0; c < NCH; c++) begin
            hit[c] = !halt && armed[c] && !cnt[sel[c]] && nxt[sel[c]];
            wr[c] = ok && cfg_ch == CHW'(c);
        end
    end

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            cnt     <= '0;
            tick    <= '0;
            armed   <= '0;
            one     <= '0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
`ifdef TICK_SCHED_ACK_EN
            ovr     <= '0;
`endif
            for (int c = 0; c < NCH; c++) sel[c] <= '0;
        end else begin
            if (!halt) cnt <= nxt;
            cfg_ack <= ok;
            cfg_err <= cfg_we && !ok;
`ifdef TICK_SCHED_ACK_EN
            tick <= hit | (tick & ~tick_ack);
            ovr  <= (ovr | (hit & tick & ~tick_ack)) & ~wr;
`else
            tick <= hit;
`endif
            for (int c = 0; c < NCH; c++) begin
                if (wr[c]) begin
                    armed[c] <= cfg_mode[0] ^ cfg_mode[1];
                    one[c]   <= cfg_mode == 2'b10;
                    sel[c]   <= cfg_sel;
                end else if (hit[c] && one[c]) begin
                    armed[c] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed and random stimulus checked every cycle against a behavioural model.
module tb_tick_sched;
    localparam int NCH = 4, CHW = 2, CW = 24, SELW = 5;

    logic            mclk = 1'b0, clr = 1'b1, halt = 1'b0, cfg_we = 1'b0;
    logic [CHW-1:0]  cfg_ch = '0;
    logic [SELW-1:0] cfg_sel = '0;
    logic [1:0]      cfg_mode = '0;
    logic            cfg_ack, cfg_err;
    logic [CW-1:0]   cnt;
    logic [NCH-1:0]  tick, armed;

    int n_chk = 0, n_fail = 0;
    longint m_cnt;
    int m_mode [NCH];
    int m_sel [NCH];
    logic [NCH-1:0] m_tick, m_armed;
    logic m_ack, m_err;

    tick_sched #(.NCH(NCH), .CHW(CHW), .CW(CW), .SELW(SELW)) dut (
        .mclk(mclk), .clr(clr), .halt(halt), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .cnt(cnt), .tick(tick), .armed(armed)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0;
            m_sel[c] = 0;
        end
        m_tick = '0;
        m_armed = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
    endtask

    // Period 2^(s+1): a rising edge of bit s lands where (v+1) mod 2^(s+1) == 2^s.
    task automatic model_edge();
        longint v = m_cnt;
        bit valid;
        m_tick = '0;
        for (int c = 0; c < NCH; c++)
            if (!halt && m_mode[c] != 0 && ((v + 1) % (64'd2 << m_sel[c])) == (64'd1 << m_sel[c])) begin
                m_tick[c] = 1'b1;
                if (m_mode[c] == 2) m_mode[c] = 0;
            end
        valid = cfg_we && int'(cfg_ch) < NCH && !((cfg_mode == 1 || cfg_mode == 2) && int'(cfg_sel) >= CW);
        m_ack = valid;
        m_err = cfg_we && !valid;
        if (valid) begin
            m_mode[cfg_ch] = (cfg_mode == 3) ? 0 : int'(cfg_mode);
            m_sel[cfg_ch] = int'(cfg_sel);
        end
        if (!halt) m_cnt = (v + 1) % (64'd1 << CW);
        for (int c = 0; c < NCH; c++) m_armed[c] = m_mode[c] != 0;
    endtask

    task automatic check_all();
        check("cnt", cnt, m_cnt);
        check("tick", tick, m_tick);
        check("armed", armed, m_armed);
        check("cfg_ack", cfg_ack, m_ack);
        check("cfg_err", cfg_err, m_err);
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
        if (clr) model_reset();
        else model_edge();
        check_all();
    endtask

    task automatic wr(input int ch, input int s, input int mode);
        cfg_we = 1'b1;
        cfg_ch = CHW'(ch);
        cfg_sel = SELW'(s);
        cfg_mode = 2'(mode);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        step();
        clr = 1'b0;
    endtask

    initial begin
        int guard;
        do_reset();

        // Mid-run asynchronous reset at cnt = 0x00A3F1.
        wr(0, 0, 1);
        guard = 0;
        while (m_cnt != 64'hA3F1 && guard < 50000) begin
            step();
            guard++;
        end
        check("reach_a3f1", cnt, 64'hA3F1);
        #2;
        clr = 1'b1;
        #1;
        check("async_cnt", cnt, 0);
        check("async_tick", tick, 0);
        check("async_armed", armed, 0);
        check("async_ack", cfg_ack, 0);
        check("async_err", cfg_err, 0);
        model_reset();
        step();
        clr = 1'b0;
        step();
        check("post_rst_armed", armed, 0);

        // Periodic ch1 with period 16, then one-shot ch2.
        do_reset();
        wr(1, 3, 1);
        repeat (48) step();
        wr(2, 2, 2);
        repeat (72) step();
        check("oneshot_disarmed", armed[2], 0);

        // Halt for 100 cycles with a fast ch0.
        wr(0, 0, 1);
        repeat (5) step();
        halt = 1'b1;
        repeat (100) step();
        check("halt_cnt", cnt, m_cnt);
        halt = 1'b0;
        repeat (20) step();

        // Invalid sel then valid write on ch3.
        wr(3, 24, 1);
        check("bad_err", cfg_err, 1);
        check("bad_ack", cfg_ack, 0);
        check("bad_armed", armed[3], 0);
        step();
        wr(3, 4, 1);
        check("good_ack", cfg_ack, 1);
        check("good_err", cfg_err, 0);
        repeat (10) step();

        // Cancel ch1 on the edge where cnt goes 7 -> 8.
        do_reset();
        wr(1, 3, 1);
        guard = 0;
        while (m_cnt != 7 && guard < 20) begin
            step();
            guard++;
        end
        check("reach_7", cnt, 7);
        wr(1, 0, 0);
        check("cancel_tick", tick[1], 1);
        check("cancel_armed", armed[1], 0);
        repeat (40) step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            halt = ($urandom_range(7) == 0);
            cfg_we = ($urandom_range(3) == 0);
            cfg_ch = CHW'($urandom_range(NCH - 1));
            cfg_sel = ($urandom_range(9) == 0) ? SELW'($urandom_range(31)) : SELW'($urandom_range(5));
            cfg_mode = 2'($urandom_range(3));
            step();
        end
        cfg_we = 1'b0;
        halt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
